// File: rtl/sum_accumulator.sv
// sum_accumulator: downstream stage of the 8-bit adder.
// Accumulates {cout, sum} terms into a frame total. A frame closes on in_last
// or after MAX_TERMS accepted terms. The result is then held under a
// valid/ready handshake until the consumer takes it.
// Optional build macro: SUM_ACCUMULATOR_SATURATE_EN clamps the total at
// 2^ACC_WIDTH-1 on overflow instead of wrapping.
module sum_accumulator #(
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 4,
  parameter int MAX_TERMS   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_sum,
  input  logic                   in_cout,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic [ACC_WIDTH-1:0]   r_out_acc;
  logic [COUNT_WIDTH-1:0] r_out_count;
  logic                   r_out_ovf;

  logic [ACC_WIDTH:0]     w_term;
  logic [ACC_WIDTH:0]     w_sum;
  logic [ACC_WIDTH-1:0]   w_acc_next;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic                   w_ovf_next;
  logic                   w_close;
  logic                   w_xfer;

  // Term datapath: 9-bit adder result widened, one guard bit above the accumulator
  always_comb begin
    w_term       = {{(ACC_WIDTH-8){1'b0}}, in_cout, in_sum};
    w_sum        = {1'b0, r_acc} + w_term;
    w_ovf_next   = r_ovf | w_sum[ACC_WIDTH];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    // Once overflow has been seen the total stays pinned at full scale
    w_acc_next   = w_ovf_next ? '1 : w_sum[ACC_WIDTH-1:0];
`else
    w_acc_next   = w_sum[ACC_WIDTH-1:0];
`endif
    w_count_next = r_count + COUNT_WIDTH'(1);
    w_close      = in_last | (w_count_next == COUNT_WIDTH'(MAX_TERMS));
  end

  // Input handshake: no acceptance while holding a result, disabled or in reset
  always_comb begin
    in_ready = ena & rst_n & (r_state != HOLD);
    w_xfer   = in_valid & in_ready;
  end

  // Frame FSM with registered result outputs; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_xfer) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if (w_close) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_out_acc   <= w_acc_next;
              r_out_count <= w_count_next;
              r_out_ovf   <= w_ovf_next;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator. Two instances share one stimulus
// stream: default width (16) and ACC_WIDTH=10 to reach overflow. The reference
// model records each frame's terms and derives total/count/overflow from the
// plain arithmetic sum of the frame.
module tb_sum_accumulator;

  localparam int MAXT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       in_last;
  logic       out_ready;

  logic        rdy_a, vld_a, ovf_a;
  logic [15:0] acc_a;
  logic [3:0]  cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [9:0]  acc_b;
  logic [3:0]  cnt_b;

  sum_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(rdy_a), .in_sum(in_sum), .in_cout(in_cout),
    .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  sum_accumulator #(.ACC_WIDTH(10), .COUNT_WIDTH(4), .MAX_TERMS(MAXT)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(rdy_b), .in_sum(in_sum), .in_cout(in_cout),
    .in_last(in_last), .out_valid(vld_b), .out_ready(out_ready),
    .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int unsigned q[$];
  bit          m_hold;
  int unsigned m_cnt;
  int unsigned m_acc_a, m_acc_b;
  bit          m_ovf_a, m_ovf_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame result from the sum of all accepted terms
  function automatic void frame_result(input int w, output int unsigned acc, output bit ovf);
    int unsigned total = 0;
    int unsigned full  = (32'd1 << w) - 1;
    foreach (q[i]) total += q[i];
    ovf = (total > full);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    acc = ovf ? full : total;
`else
    acc = total % (32'd1 << w);
`endif
  endfunction

  task automatic drive(input bit e, input bit v, input int unsigned term, input bit l, input bit r);
    ena       = e;
    in_valid  = v;
    in_cout   = term[8];
    in_sum    = term[7:0];
    in_last   = l;
    out_ready = r;
  endtask

  // One clock: check in_ready, advance the model across the edge, check outputs
  task automatic tick();
    bit          xfer, take, l;
    int unsigned t;
    #1;
    check_eq("in_ready", rdy_a, ena && !m_hold);
    check_eq("in_ready_w10", rdy_b, ena && !m_hold);
    xfer = ena && in_valid && !m_hold;
    take = ena && out_ready && m_hold;
    t    = {23'd0, in_cout, in_sum};
    l    = in_last;
    @(posedge clk);
    if (xfer) begin
      q.push_back(t);
      if (l || q.size() == MAXT) begin
        frame_result(16, m_acc_a, m_ovf_a);
        frame_result(10, m_acc_b, m_ovf_b);
        m_cnt  = q.size();
        m_hold = 1'b1;
        q.delete();
      end
    end else if (take) begin
      m_hold = 1'b0;
    end
    #1;
    check_eq("out_valid", vld_a, m_hold);
    check_eq("out_valid_w10", vld_b, m_hold);
    if (m_hold) begin
      check_eq("out_acc", acc_a, m_acc_a);
      check_eq("out_count", cnt_a, m_cnt);
      check_eq("out_ovf", ovf_a, m_ovf_a);
      check_eq("out_acc_w10", acc_b, m_acc_b);
      check_eq("out_count_w10", cnt_b, m_cnt);
      check_eq("out_ovf_w10", ovf_b, m_ovf_b);
    end
  endtask

  task automatic consume();
    drive(1, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0);
  endtask

  // Reset pulse between clock edges; outputs must clear before the next edge
  task automatic async_reset(input string tag);
    ena      = 1'b1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_valid"}, vld_a, 0);
    check_eq({tag, "_acc"}, acc_a, 0);
    check_eq({tag, "_count"}, cnt_a, 0);
    check_eq({tag, "_ovf"}, ovf_a, 0);
    check_eq({tag, "_ready"}, rdy_a, 0);
    check_eq({tag, "_valid_w10"}, vld_b, 0);
    q.delete();
    m_hold = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    m_hold = 1'b0;
    #1;
    check_eq("rst_valid", vld_a, 0);
    check_eq("rst_acc", acc_a, 0);
    check_eq("rst_count", cnt_a, 0);
    check_eq("rst_ovf", ovf_a, 0);
    check_eq("rst_ready", rdy_a, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four adder results, last on the 4th
    drive(1, 1, 9'h013, 0, 0); tick();
    drive(1, 1, 9'h0FF, 0, 0); tick();
    drive(1, 1, 9'h0FF, 0, 0); tick();
    drive(1, 1, 9'h100, 1, 0); tick();
    check_eq("A_acc", acc_a, 16'h0311);
    check_eq("A_count", cnt_a, 4);
    check_eq("A_ovf", ovf_a, 0);
    // Backpressure: result held, no acceptance
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 9'h055, 0, 0);
      tick();
    end
    check_eq("A_held_acc", acc_a, 16'h0311);
    consume();
    check_eq("A_consumed", vld_a, 0);

    // Forced close after MAX_TERMS terms
    for (int i = 0; i < MAXT; i++) begin
      drive(1, 1, 9'h001, 0, 0);
      tick();
    end
    check_eq("B_acc", acc_a, 8);
    check_eq("B_count", cnt_a, 8);
    drive(1, 1, 9'h001, 0, 0); tick();
    consume();

    // Overflow on the 10-bit instance
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 9'h100, i == 3, 0);
      tick();
    end
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    check_eq("C_acc_w10", acc_b, 10'h3FF);
`else
    check_eq("C_acc_w10", acc_b, 10'h000);
`endif
    check_eq("C_ovf_w10", ovf_b, 1);
    check_eq("C_acc_w16", acc_a, 16'h0400);
    consume();

    // Enable dropped mid-frame with in_valid high
    drive(1, 1, 9'h010, 0, 0); tick();
    drive(1, 1, 9'h020, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 9'h1FF, 1, 1);
      tick();
    end
    drive(1, 1, 9'h030, 0, 0); tick();
    drive(1, 1, 9'h040, 1, 0); tick();
    check_eq("D_acc", acc_a, 16'h00A0);
    check_eq("D_count", cnt_a, 4);
    consume();

    // Asynchronous reset mid-frame, then a single-term frame
    drive(1, 1, 9'h0AA, 0, 0); tick();
    drive(1, 1, 9'h0BB, 0, 0); tick();
    async_reset("E_rst");
    drive(1, 1, 9'h005, 1, 0); tick();
    check_eq("E_acc", acc_a, 5);
    check_eq("E_count", cnt_a, 1);
    // Reset while holding a result discards it
    drive(1, 0, 0, 0, 0); tick();
    async_reset("E_hold_rst");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 510), $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
